// File: rtl/ex_cdb_stage_if.sv
// EX_PACKET definition and the bundle of FU-side, CDB-side and broadcast signals
// that connect the execute units, the ex_cdb_stage and the CDB buffer.
package ex_cdb_pkg;
  localparam int BMASK_W = 4;

  typedef struct packed {
    logic               valid;
    logic [BMASK_W-1:0] branch_tag;
    logic [5:0]         dest_tag;
    logic [31:0]        result;
  } EX_PACKET;
endpackage

interface ex_cdb_stage_if;
  import ex_cdb_pkg::*;

  EX_PACKET           alu_in;
  EX_PACKET           mul_in;
  EX_PACKET           load_in;
  logic               cdb_valid;
  logic               cdb_squash_enable;
  logic [BMASK_W-1:0] cdb_branch_mask;
  EX_PACKET           alu_packet;
  EX_PACKET           mul_packet;
  EX_PACKET           load_packet;
  logic               alu_ready;
  logic               mul_ready;
  logic               load_ready;

  // master: the FU/CDB environment around the stage
  modport master (
    output alu_in, mul_in, load_in, cdb_valid, cdb_squash_enable, cdb_branch_mask,
    input  alu_packet, mul_packet, load_packet, alu_ready, mul_ready, load_ready
  );

  modport slave (
    input  alu_in, mul_in, load_in, cdb_valid, cdb_squash_enable, cdb_branch_mask,
    output alu_packet, mul_packet, load_packet, alu_ready, mul_ready, load_ready
  );
endinterface

// File: rtl/ex_cdb_stage.sv
// Skid stage between the ALU/MUL/LOAD units and the CDB: per-lane FIFOs, branch squash/resolve
// on everything held, and ALU/MUL arbitration. Define ROUND_ROBIN_ARB_EN for round-robin ALU/MUL.
module ex_cdb_stage
  import ex_cdb_pkg::*;
#(
  parameter int LANE_DEPTH   = 2,
  parameter int STARVE_LIMIT = 3
) (
  input logic           clock,
  input logic           reset,
  ex_cdb_stage_if.slave bus
);

  localparam int PTR_W     = $clog2(LANE_DEPTH);
  localparam int CNT_W     = PTR_W + 1;
  localparam int NLANES    = 3;
  localparam int LANE_ALU  = 0;
  localparam int LANE_MUL  = 1;
  localparam int LANE_LOAD = 2;

  EX_PACKET         mem_q   [NLANES][LANE_DEPTH];
  EX_PACKET         mem_d   [NLANES][LANE_DEPTH];
  logic [PTR_W-1:0] head_q  [NLANES];
  logic [PTR_W-1:0] head_d  [NLANES];
  logic [PTR_W-1:0] tail_q  [NLANES];
  logic [PTR_W-1:0] tail_d  [NLANES];
  logic [CNT_W-1:0] count_q [NLANES];
  logic [CNT_W-1:0] count_d [NLANES];

  EX_PACKET          rawIn   [NLANES];
  EX_PACKET          inPkt   [NLANES];
  EX_PACKET          headPkt [NLANES];
  logic [NLANES-1:0] ready;
  logic [NLANES-1:0] occupied;
  logic [NLANES-1:0] live;
  logic [NLANES-1:0] push;
  logic [NLANES-1:0] pop;
  logic [NLANES-1:0] present;
  logic              squashNow;
  logic              resolveNow;
  logic              aluWins;
  logic              mulWins;

`ifdef ROUND_ROBIN_ARB_EN
  logic lastMul_q, lastMul_d;
`else
  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
  logic [STARVE_W-1:0] starve_q, starve_d;
`endif

  // One broadcast rule for stored entries, the presented head and incoming packets alike.
  function automatic EX_PACKET applyBcast(input EX_PACKET p, input logic sq, input logic rs,
                                          input logic [BMASK_W-1:0] mask);
    EX_PACKET r;
    r = p;
    if (sq && ((p.branch_tag & mask) != '0)) r.valid = 1'b0;
    if (rs) r.branch_tag = p.branch_tag & ~mask;
    return r;
  endfunction

  always_comb begin
    squashNow  = bus.cdb_valid & bus.cdb_squash_enable;
    resolveNow = bus.cdb_valid & ~bus.cdb_squash_enable;
    rawIn[LANE_ALU]  = bus.alu_in;
    rawIn[LANE_MUL]  = bus.mul_in;
    rawIn[LANE_LOAD] = bus.load_in;

    for (int l = 0; l < NLANES; l++) begin
      ready[l]    = count_q[l] < CNT_W'(LANE_DEPTH);
      inPkt[l]    = applyBcast(rawIn[l], squashNow, resolveNow, bus.cdb_branch_mask);
      push[l]     = inPkt[l].valid & ready[l];
      headPkt[l]  = applyBcast(mem_q[l][head_q[l]], squashNow, resolveNow, bus.cdb_branch_mask);
      occupied[l] = count_q[l] != '0;
      live[l]     = occupied[l] & headPkt[l].valid;
    end

`ifdef ROUND_ROBIN_ARB_EN
    if (live[LANE_ALU] && live[LANE_MUL]) mulWins = ~lastMul_q;
    else                                  mulWins = live[LANE_MUL];
    aluWins   = live[LANE_ALU] & ~mulWins;
    lastMul_d = lastMul_q;
    if (aluWins)      lastMul_d = 1'b0;
    else if (mulWins) lastMul_d = 1'b1;
`else
    // MUL only overrides ALU once it has lost STARVE_LIMIT contests in a row.
    mulWins  = live[LANE_MUL] & (~live[LANE_ALU] | (starve_q == STARVE_W'(STARVE_LIMIT)));
    aluWins  = live[LANE_ALU] & ~mulWins;
    starve_d = starve_q;
    if (mulWins || !live[LANE_MUL])               starve_d = '0;
    else if (starve_q != STARVE_W'(STARVE_LIMIT)) starve_d = starve_q + STARVE_W'(1);
`endif

    present[LANE_ALU]  = aluWins;
    present[LANE_MUL]  = mulWins;
    present[LANE_LOAD] = live[LANE_LOAD];

    // A dead head leaves silently; a live head leaves only when it is presented.
    for (int l = 0; l < NLANES; l++) begin
      pop[l] = occupied[l] & (~headPkt[l].valid | present[l]);
      for (int s = 0; s < LANE_DEPTH; s++) begin
        mem_d[l][s] = applyBcast(mem_q[l][s], squashNow, resolveNow, bus.cdb_branch_mask);
      end
      if (push[l]) mem_d[l][tail_q[l]] = inPkt[l];
      head_d[l]  = head_q[l] + PTR_W'(pop[l]);
      tail_d[l]  = tail_q[l] + PTR_W'(push[l]);
      count_d[l] = count_q[l] + CNT_W'(push[l]) - CNT_W'(pop[l]);
    end

    bus.alu_packet  = present[LANE_ALU]  ? headPkt[LANE_ALU]  : '0;
    bus.mul_packet  = present[LANE_MUL]  ? headPkt[LANE_MUL]  : '0;
    bus.load_packet = present[LANE_LOAD] ? headPkt[LANE_LOAD] : '0;
    bus.alu_ready   = ready[LANE_ALU];
    bus.mul_ready   = ready[LANE_MUL];
    bus.load_ready  = ready[LANE_LOAD];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int l = 0; l < NLANES; l++) begin
        for (int s = 0; s < LANE_DEPTH; s++) mem_q[l][s] <= '0;
        head_q[l]  <= '0;
        tail_q[l]  <= '0;
        count_q[l] <= '0;
      end
`ifdef ROUND_ROBIN_ARB_EN
      lastMul_q <= 1'b1;
`else
      starve_q  <= '0;
`endif
    end else begin
      for (int l = 0; l < NLANES; l++) begin
        for (int s = 0; s < LANE_DEPTH; s++) mem_q[l][s] <= mem_d[l][s];
        head_q[l]  <= head_d[l];
        tail_q[l]  <= tail_d[l];
        count_q[l] <= count_d[l];
      end
`ifdef ROUND_ROBIN_ARB_EN
      lastMul_q <= lastMul_d;
`else
      starve_q  <= starve_d;
`endif
    end
  end

endmodule

// File: doc/ex_cdb_stage.md
Name: ex_cdb_stage

Overview:
Pipeline/skid stage between the execute units (ALU, MUL, LOAD) and the CDB buffer.
- Holds completed EX_PACKETs in small per-lane FIFOs.
- Presents at most one load packet plus one of {ALU, MUL} per cycle, so the CDB never sees an ALU+MUL conflict.
- Performs all branch squashing and branch-tag clearing, so packets reaching the CDB are pre-squashed.
- Backpressures the functional units through per-lane ready signals.

Parameters:
- LANE_DEPTH, 2: entries per lane FIFO (power of 2, ≥2).
- STARVE_LIMIT, 3: consecutive cycles a valid MUL head may lose arbitration before it gets priority.
- BMASK_W, 4: branch mask/tag width; equals the EX_PACKET.branch_tag width.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- alu_in  in  $bits(EX_PACKET)  ALU result; enqueued when .valid and alu_ready.
- mul_in  in  $bits(EX_PACKET)  MUL result; enqueued when .valid and mul_ready.
- load_in  in  $bits(EX_PACKET)  LOAD result; enqueued when .valid and load_ready.
- cdb_valid  in  1  the CDB head broadcast is valid this cycle.
- cdb_squash_enable  in  1  the broadcast branch mispredicted.
- cdb_branch_mask  in  BMASK_W  one-hot mask of the resolving branch.
- alu_packet  out  $bits(EX_PACKET)  to CDB alu_packet.
- mul_packet  out  $bits(EX_PACKET)  to CDB mul_packet.
- load_packet  out  $bits(EX_PACKET)  to CDB load_packet.
- alu_ready, mul_ready, load_ready  out  1 each  lane can accept a packet this cycle.

Behaviour:
- Reset (async, active-high):
  - All FIFOs empty; head and tail pointers 0; starve counter 0.
  - All output packets have .valid=0 (other fields 0).
  - All ready signals = 1.
  - Asserting reset mid-operation discards every held packet immediately.
- Each lane is a circular FIFO of LANE_DEPTH entries with a registered count.
  - ready = (count < LANE_DEPTH). Ready uses the registered count and does not credit a same-cycle pop.
  - A valid input while ready=0 is a FU protocol violation; the bench asserts it never occurs.
- Latency: a packet accepted at edge N is presentable in cycle N+1 at the earliest. There is no combinational input-to-output path.
- Broadcast processing, applied every cycle to all stored entries and to the incoming packets before enqueue:
  - Squash (cdb_valid & cdb_squash_enable): any entry with (branch_tag & cdb_branch_mask) != 0 gets .valid=0. Squashed incoming packets are not enqueued and do not consume a slot.
  - Resolve (cdb_valid & ~cdb_squash_enable): branch_tag &= ~cdb_branch_mask on every entry and incoming packet.
- Invalidated stored entries keep their slot until they reach the head. An invalid head is popped silently, one per lane per cycle, without being presented.
- Output gating: an output packet is the lane head, with .valid = head.valid & head not hit by a same-cycle squash. Branch_tag is presented with same-cycle resolve clearing applied.
- Load lane: a valid head is always presented and popped on that cycle's edge. The CDB accepts the load unconditionally.
- ALU/MUL arbitration: at most one of alu_packet/mul_packet is valid per cycle. The winner is presented and popped; the loser holds.
  - Default priority is ALU.
  - The starve counter increments each cycle the MUL head is valid but loses, and saturates at STARVE_LIMIT.
  - When the counter equals STARVE_LIMIT, MUL wins and the counter clears. The counter also clears whenever MUL wins or its head is invalid/empty.
- Simultaneous push and pop on one lane: count unchanged, both pointers advance. Pointers wrap modulo LANE_DEPTH.

Optional Feature:
ROUND_ROBIN_ARB_EN.
- Defined: the starve counter is removed. A 1-bit last-winner register (reset to MUL, so ALU wins the first contest) alternates the winner whenever both heads are valid. With one valid head, that head wins and the register updates.
- Undefined: fixed ALU priority with STARVE_LIMIT escalation, as in Behaviour.

Test Plan:
1. Reset then single ALU packet (tag 5) at cycle 1 → alu_packet.valid=1, tag 5 in cycle 2; alu_ready stays 1.
2. ALU and MUL valid every cycle, STARVE_LIMIT=3 → ALU,ALU,ALU,MUL repeating. Exactly one of alu/mul output valid per cycle; load_packet unaffected.
3. Fill MUL lane (2 packets, ALU continuously busy) → mul_ready=0. Third MUL is held at the FU until a pop; no packet is lost or duplicated.
4. Held ALU packets with branch_tag 4'b0010 and 4'b0001, broadcast squash mask 4'b0010 → first never presented and popped silently; second presented next.
5. Held packet with tag 4'b0110, broadcast resolve mask 4'b0100 → presented with tag 4'b0010 (the same cycle if at head).
6. Async reset asserted mid-cycle with all lanes full → outputs invalid and readies 1 before the next clock edge. With ROUND_ROBIN_ARB_EN defined, ALU/MUL contention yields strict alternation starting with ALU.
